// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage (port 0)
// and the address/branch-compare unit (port 1); one operation in flight at a time.
module alu_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [6:0]       req0_funct7_i,
    input  logic [2:0]       req0_funct3_i,
    input  logic [XLEN-1:0]  req0_a_i,
    input  logic [XLEN-1:0]  req0_b_i,
    input  logic [TAG_W-1:0] req0_tag_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [6:0]       req1_funct7_i,
    input  logic [2:0]       req1_funct3_i,
    input  logic [XLEN-1:0]  req1_a_i,
    input  logic [XLEN-1:0]  req1_b_i,
    input  logic [TAG_W-1:0] req1_tag_i,

    output logic [6:0]       alu_funct7_o,
    output logic [2:0]       alu_funct3_o,
    output logic [XLEN-1:0]  alu_a_o,
    output logic [XLEN-1:0]  alu_b_o,
    input  logic [XLEN-1:0]  alu_result_i,
    input  logic [3:0]       alu_flags_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic [XLEN-1:0]  rsp_result_o,
    output logic [3:0]       rsp_flags_o
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q, state_d;
    logic              last_q;
    logic              grant0, grant1, accept;
    logic [6:0]        alu_funct7_q;
    logic [2:0]        alu_funct3_q;
    logic [XLEN-1:0]   alu_a_q, alu_b_q;
    logic              rsp_id_q;
    logic [TAG_W-1:0]  rsp_tag_q;
    logic [XLEN-1:0]   rsp_result_q;
    logic [3:0]        rsp_flags_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = flush_i ? StIdle : StResp;
            StResp:  if (flush_i || rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        // last_q == 1 means port 1 was served most recently, so port 0 has priority.
        grant0       = req0_valid_i & (~req1_valid_i | last_q);
        grant1       = req1_valid_i & ~grant0;
        req0_ready_o = rst_ni & (state_q == StIdle) & ~flush_i & grant0;
        req1_ready_o = rst_ni & (state_q == StIdle) & ~flush_i & grant1;
        accept       = req0_ready_o | req1_ready_o;
        rsp_valid_o  = (state_q == StResp);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q       <= 1'b1;
            alu_funct7_q <= '0;
            alu_funct3_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            if (accept) begin
                last_q       <= grant1;
                alu_funct7_q <= grant1 ? req1_funct7_i : req0_funct7_i;
                alu_funct3_q <= grant1 ? req1_funct3_i : req0_funct3_i;
                alu_a_q      <= grant1 ? req1_a_i : req0_a_i;
                alu_b_q      <= grant1 ? req1_b_i : req0_b_i;
                rsp_id_q     <= grant1;
                rsp_tag_q    <= grant1 ? req1_tag_i : req0_tag_i;
            end
            if (state_q == StExec && !flush_i) begin
                rsp_result_q <= alu_result_i;
                rsp_flags_q  <= alu_flags_i;
            end
        end
    end

    assign alu_funct7_o = alu_funct7_q;
    assign alu_funct3_o = alu_funct3_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_tag_o    = rsp_tag_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_flags_o  = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural RV32 ALU closes the loop, a round-robin reference
// model predicts grants, and each scenario checks responses inline.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [6:0]  req0_funct7, req1_funct7, alu_funct7;
    logic [2:0]  req0_funct3, req1_funct3, alu_funct3;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
    logic [1:0]  req0_tag, req1_tag, rsp_tag;
    logic [3:0]  alu_flags, rsp_flags;
    logic        rsp_valid, rsp_ready, rsp_id;

    int checks = 0;
    int failures = 0;
    bit m_last;  // reference: 1 when port 1 was served last

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(32), .TAG_W(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_funct7_i(req0_funct7),
        .req0_funct3_i(req0_funct3), .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_tag_i(req0_tag),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_funct7_i(req1_funct7),
        .req1_funct3_i(req1_funct3), .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_tag_i(req1_tag),
        .alu_funct7_o(alu_funct7), .alu_funct3_o(alu_funct3), .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_result_i(alu_result), .alu_flags_i(alu_flags),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_tag_o(rsp_tag), .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags)
    );

    function automatic logic [31:0] alu_fn(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'd0:    r = f7[5] ? a - b : a + b;
            3'd1:    r = a << b[4:0];
            3'd2:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    r = (a < b) ? 32'd1 : 32'd0;
            3'd4:    r = a ^ b;
            3'd5:    r = f7[5] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] flags_fn(input logic [31:0] r, input logic [31:0] a,
                                            input logic [31:0] b);
        return {r == 32'd0, r[31], a == b, $signed(a) < $signed(b)};
    endfunction

    assign alu_result = alu_fn(alu_funct7, alu_funct3, alu_a, alu_b);
    assign alu_flags  = flags_fn(alu_result, alu_a, alu_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [1:0] tg);
        if (p == 0) begin
            req0_valid = 1'b1; req0_funct7 = f7; req0_funct3 = f3;
            req0_a = a; req0_b = b; req0_tag = tg;
        end else begin
            req1_valid = 1'b1; req1_funct7 = f7; req1_funct3 = f3;
            req1_a = a; req1_b = b; req1_tag = tg;
        end
    endtask

    task automatic clear_reqs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        drive(0, 7'h00, 3'd0, 32'd1, 32'd2, 2'd1);
        drive(1, 7'h00, 3'd0, 32'd3, 32'd4, 2'd2);
        tick();
        tick();
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=00", {req1_ready, req0_ready});
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_flags} !== 40'd0) begin
            failures++;
            $display("FAIL reset_rsp got=%b/%b/%h/%h/%h exp=all zero",
                     rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_flags);
        end
        checks++;
        if ({alu_funct7, alu_funct3, alu_a, alu_b} !== 74'd0) begin
            failures++;
            $display("FAIL reset_alu got=%h/%h/%h/%h exp=all zero",
                     alu_funct7, alu_funct3, alu_a, alu_b);
        end
        clear_reqs();
        rst_n = 1'b1;
        m_last = 1'b1;
        tick();
    endtask

    task automatic test_both_ports();
        bit w;
        rsp_ready = 1'b1;
        drive(0, 7'h20, 3'd0, 32'd20, 32'd30, 2'd2);
        drive(1, 7'h00, 3'd3, 32'd3, 32'd4, 2'd3);
        for (int i = 0; i < 4; i++) begin
            w = m_last ? 1'b0 : 1'b1;
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== (w ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL both_grant op=%0d got=%b exp_port=%0d", i,
                         {req1_ready, req0_ready}, w);
            end
            tick();
            m_last = w;
            tick();
            checks++;
            if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, w, (w ? 32'd1 : 32'hFFFF_FFF6)}) begin
                failures++;
                $display("FAIL both_rsp op=%0d got=%b/%b/%h exp=1/%0d/%h", i, rsp_valid,
                         rsp_id, rsp_result, w, (w ? 32'd1 : 32'hFFFF_FFF6));
            end
            checks++;
            if ({req1_ready, req0_ready} !== 2'b00) begin
                failures++;
                $display("FAIL both_ready_in_resp op=%0d got=%b exp=00", i,
                         {req1_ready, req0_ready});
            end
            tick();
        end
        clear_reqs();
        rsp_ready = 1'b0;
    endtask

    task automatic test_single_add();
        rsp_ready = 1'b1;
        drive(0, 7'h00, 3'd0, 32'd20, 32'd30, 2'd1);
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL add_ready got=%b exp=1", req0_ready);
        end
        tick();
        m_last = 1'b0;
        clear_reqs();
        checks++;
        if ({rsp_valid, alu_a, alu_b} !== {1'b0, 32'd20, 32'd30}) begin
            failures++;
            $display("FAIL add_exec got=%b/%h/%h exp=0/14/1e", rsp_valid, alu_a, alu_b);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_result, rsp_id, rsp_tag, rsp_flags} !==
            {1'b1, 32'd50, 1'b0, 2'd1, flags_fn(32'd50, 32'd20, 32'd30)}) begin
            failures++;
            $display("FAIL add_rsp got=%b/%h/%b/%h/%h exp=1/32/0/1/%h", rsp_valid, rsp_result,
                     rsp_id, rsp_tag, rsp_flags, flags_fn(32'd50, 32'd20, 32'd30));
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_release got=%b exp=0", rsp_valid);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        drive(1, 7'h00, 3'd4, 32'hF0F0_F0F0, 32'h00FF_FF00, 2'd2);
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            failures++;
            $display("FAIL bp_grant got=%b exp=10", {req1_ready, req0_ready});
        end
        tick();
        m_last = 1'b1;
        drive(0, 7'h00, 3'd0, 32'd5, 32'd6, 2'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_tag, rsp_result, req1_ready, req0_ready} !==
                {1'b1, 1'b1, 2'd2, 32'hF00F_0FF0, 2'b00}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%b/%b/%h/%h/%b%b exp=1/1/2/f00f0ff0/00", i,
                         rsp_valid, rsp_id, rsp_tag, rsp_result, req1_ready, req0_ready);
            end
            tick();
        end
        clear_reqs();
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got=%b exp=0", rsp_valid);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_flush();
        rsp_ready = 1'b1;
        drive(0, 7'h00, 3'd7, 32'hF0FF_F0F0, 32'hFF00_00FF, 2'd3);
        flush = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_block got=%b exp=0", req0_ready);
        end
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle_after got=%b exp=1", req0_ready);
        end
        tick();
        m_last = 1'b0;
        clear_reqs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_exec_drop cyc=%0d got=%b exp=0", i, rsp_valid);
            end
            if (i == 0) tick();
        end
        // Flush leaves the pointer alone, so a lone port-0 request still wins here.
        drive(0, 7'h00, 3'd2, 32'hFFFF_FFFC, 32'd3, 2'd1);
        #1;
        tick();
        m_last = 1'b0;
        clear_reqs();
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'd1}) begin
            failures++;
            $display("FAIL flush_next_slt got=%b/%b/%h exp=1/0/1", rsp_valid, rsp_id, rsp_result);
        end
        tick();
        rsp_ready = 1'b0;
        drive(1, 7'h00, 3'd6, 32'd1, 32'd2, 2'd0);
        tick();
        m_last = 1'b1;
        clear_reqs();
        tick();
        flush = 1'b1;
        rsp_ready = 1'b1;
        tick();
        flush = 1'b0;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_resp_clear got=%b exp=0", rsp_valid);
        end
        // Both waiting: port 1 was last accepted, so port 0 must be granted.
        drive(0, 7'h00, 3'd0, 32'd1, 32'd1, 2'd0);
        drive(1, 7'h00, 3'd0, 32'd2, 32'd2, 2'd0);
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL flush_keeps_last got=%b exp=01", {req1_ready, req0_ready});
        end
        clear_reqs();
        tick();
    endtask

    task automatic test_reset_in_resp();
        rsp_ready = 1'b0;
        drive(1, 7'h00, 3'd0, 32'd7, 32'd8, 2'd3);
        #1;
        tick();
        clear_reqs();
        tick();
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_resp_pending got=%b exp=1", rsp_valid);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_flags} !== 40'd0) begin
            failures++;
            $display("FAIL rst_resp_clear got=%b/%b/%h/%h/%h exp=all zero",
                     rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_flags);
        end
        rst_n = 1'b1;
        m_last = 1'b1;
        drive(0, 7'h00, 3'd0, 32'd9, 32'd1, 2'd1);
        drive(1, 7'h00, 3'd0, 32'd9, 32'd2, 2'd2);
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rst_first_grant got=%b exp=01", {req1_ready, req0_ready});
        end
        tick();
        m_last = 1'b0;
        clear_reqs();
        rsp_ready = 1'b1;
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_result} !== {1'b1, 1'b0, 2'd1, 32'd10}) begin
            failures++;
            $display("FAIL rst_first_rsp got=%b/%b/%h/%h exp=1/0/1/a", rsp_valid, rsp_id,
                     rsp_tag, rsp_result);
        end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [6:0]  f7 [2];
        logic [2:0]  f3 [2];
        logic [31:0] a [2];
        logic [31:0] b [2];
        logic [1:0]  tg [2];
        logic [31:0] exp_r;
        logic [3:0]  exp_f;
        bit          v0, v1, w;
        int          stall;
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < 2; p++) begin
                f7[p] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
                f3[p] = 3'($urandom_range(0, 7));
                a[p]  = $urandom;
                b[p]  = $urandom;
                tg[p] = 2'($urandom_range(0, 3));
            end
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v0) drive(0, f7[0], f3[0], a[0], b[0], tg[0]);
            if (v1) drive(1, f7[1], f3[1], a[1], b[1], tg[1]);
            w = (v0 && (!v1 || m_last)) ? 1'b0 : 1'b1;
            exp_r = alu_fn(f7[w], f3[w], a[w], b[w]);
            exp_f = flags_fn(exp_r, a[w], b[w]);
            rsp_ready = 1'b0;
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== (w ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL rnd_grant op=%0d v=%b%b got=%b exp_port=%0d", i, v1, v0,
                         {req1_ready, req0_ready}, w);
            end
            tick();
            m_last = w;
            clear_reqs();
            checks++;
            if ({rsp_valid, alu_funct7, alu_funct3, alu_a, alu_b} !==
                {1'b0, f7[w], f3[w], a[w], b[w]}) begin
                failures++;
                $display("FAIL rnd_operands op=%0d got=%b/%h/%h/%h/%h exp=0/%h/%h/%h/%h", i,
                         rsp_valid, alu_funct7, alu_funct3, alu_a, alu_b,
                         f7[w], f3[w], a[w], b[w]);
            end
            tick();
            stall = $urandom_range(0, 3);
            for (int s = 0; s <= stall; s++) begin
                if (s == stall) rsp_ready = 1'b1;
                #1;
                checks++;
                if ({rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_flags} !==
                    {1'b1, w, tg[w], exp_r, exp_f}) begin
                    failures++;
                    $display("FAIL rnd_rsp op=%0d cyc=%0d got=%b/%b/%h/%h/%h exp=1/%0d/%h/%h/%h",
                             i, s, rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_flags,
                             w, tg[w], exp_r, exp_f);
                end
                tick();
            end
            rsp_ready = 1'b0;
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rnd_release op=%0d got=%b exp=0", i, rsp_valid);
            end
        end
    endtask

    initial begin
        req0_funct7 = '0; req0_funct3 = '0; req0_a = '0; req0_b = '0; req0_tag = '0;
        req1_funct7 = '0; req1_funct3 = '0; req1_a = '0; req1_b = '0; req1_tag = '0;
        clear_reqs();
        test_reset();
        test_both_ports();
        test_single_add();
        test_backpressure();
        test_flush();
        test_reset_in_resp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
